// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants for the memory-access stage
package mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WORD_ADDR_W = 30;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// rtl/dmem_timeout_ctr.sv - 8-bit BUSY-cycle counter flagging the last allowed cycle
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store stage driving a req/ack data-memory bus
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   VALID,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [31:0]            ALU_res,
  input  logic [31:0]            WriteData,
  input  logic                   RegWrite,
  output logic                   STALL,
  output logic                   RegWrite_out,
  output logic [31:0]            ReadData,
  output logic                   FAULT,
  output logic                   DMEM_REQ,
  output logic                   DMEM_WE,
  output logic [WORD_ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]            DMEM_WDATA,
  input  logic                   DMEM_ACK,
  input  logic [31:0]            DMEM_RDATA
);

  logic [1:0]  state, next_state;
  logic [1:0]  fault_cause;
  logic        memop, misaligned;
  logic        stall_c, rw_c;
  logic        capture, ctr_clear, ctr_en, expired;
  logic [31:0] rd_q;
  logic        rw_q;

  assign memop      = VALID & (MemRead | MemWrite);
  assign misaligned = (ALU_res[1:0] != 2'b00);

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst_n   (RESET),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (expired)
  );

  always_comb begin
    next_state  = state;
    stall_c     = 1'b0;
    rw_c        = 1'b0;
    fault_cause = FAULT_NONE;
    capture     = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!memop) begin
          rw_c = VALID & RegWrite;
        end else if (misaligned) begin
          fault_cause = FAULT_MISALIGN;
        end else begin
          stall_c    = 1'b1;
          capture    = 1'b1;
          ctr_clear  = 1'b1;
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        // ACK wins over expiry when both land in the final allowed cycle
        if (DMEM_ACK) begin
          next_state = ST_DONE;
        end else if (expired) begin
          fault_cause = FAULT_TIMEOUT;
          next_state  = ST_DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_DONE: begin
        rw_c       = rw_q;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Reset forces the combinational outputs low even while EX/MEM still holds a memop
  assign STALL        = RESET & stall_c;
  assign RegWrite_out = RESET & rw_c;
  assign FAULT        = RESET & (fault_cause != FAULT_NONE);
  assign ReadData     = rd_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      DMEM_REQ   <= 1'b0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= 32'd0;
      rd_q       <= 32'd0;
      rw_q       <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        DMEM_REQ   <= 1'b1;
        DMEM_WE    <= MemWrite;
        DMEM_ADDR  <= ALU_res[31:2];
        DMEM_WDATA <= WriteData;
        rw_q       <= RegWrite & ~MemWrite;
      end
      if (state == ST_BUSY) begin
        if (DMEM_ACK) begin
          DMEM_REQ <= 1'b0;
          rd_q     <= DMEM_WE ? 32'd0 : DMEM_RDATA;
        end else if (expired) begin
          DMEM_REQ <= 1'b0;
          rd_q     <= 32'd0;
          rw_q     <= 1'b0;
        end
      end
      // Read register only holds the result for the DONE cycle
      if (state == ST_DONE) begin
        rd_q <= 32'd0;
      end
    end
  end

endmodule
